// File: rtl/ct_loader.sv
// Ciphertext loader: writes a length-prefixed byte stream (L, then L bytes) into ct_mem at 0..L.
// Latency: an accepted byte is written on the next cycle; done pulses two cycles after the final accept.
// Backpressure: in_ready is high only in LEN/DATA; in_valid=0 stalls with no write and no state change.
module ct_loader #(
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  output logic                         rdy,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  output logic [$clog2(MEM_DEPTH)-1:0] ct_addr,
  output logic [7:0]                   ct_wrdata,
  output logic                         ct_wren,
  output logic                         done,
  output logic [7:0]                   checksum
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEN   = 2'd1,
    DATA  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Datapath registers; the write port is fully registered so ct_mem sees clean flop outputs.
  logic [7:0]    len_q, len_d;
  logic [AW-1:0] index_q, index_d;
  logic [7:0]    checksum_q, checksum_d;
  logic          ct_wren_q, ct_wren_d;
  logic [AW-1:0] ct_addr_q, ct_addr_d;
  logic [7:0]    ct_wrdata_q, ct_wrdata_d;
  logic          done_q, done_d;

  // Handshake qualifier shared by the next-state and datapath logic.
  logic accept;

  // State register; reset parks the FSM in IDLE and aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: en is only looked at in IDLE, so a pulse mid-job is simply ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) state_d = LEN;
      end
      LEN: begin
        if (accept) state_d = (in_data == 8'd0) ? FLUSH : DATA;
      end
      DATA: begin
        if (accept && (index_q == AW'(len_q))) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state; rdy and in_ready are never high together.
  always_comb begin
    rdy      = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE:    rdy      = 1'b1;
      LEN:     in_ready = 1'b1;
      DATA:    in_ready = 1'b1;
      FLUSH:   in_ready = 1'b0;
      default: rdy      = 1'b0;
    endcase
    accept = in_ready & in_valid;
  end

  // Datapath next values: latch L, walk the index, fold data into the checksum, stage the write.
  always_comb begin
    len_d       = len_q;
    index_d     = index_q;
    checksum_d  = checksum_q;
    ct_wren_d   = 1'b0;
    ct_addr_d   = ct_addr_q;
    ct_wrdata_d = ct_wrdata_q;
    // FLUSH always lasts one cycle, so done lands on the first IDLE cycle together with rdy.
    done_d      = (state_q == FLUSH);
    case (state_q)
      IDLE: begin
        if (en) checksum_d = 8'd0;
      end
      LEN: begin
        if (accept) begin
          len_d       = in_data;
          index_d     = AW'(1);
          ct_wren_d   = 1'b1;
          ct_addr_d   = '0;
          ct_wrdata_d = in_data;
        end
      end
      DATA: begin
        if (accept) begin
          ct_wren_d   = 1'b1;
          ct_addr_d   = index_q;
          ct_wrdata_d = in_data;
          checksum_d  = checksum_q ^ in_data;
          // Hold the index on the last byte so L=255 never wraps back to address 0.
          if (index_q != AW'(len_q)) index_d = index_q + AW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; everything clears asynchronously so outputs hit reset values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= 8'd0;
      index_q     <= '0;
      checksum_q  <= 8'd0;
      ct_wren_q   <= 1'b0;
      ct_addr_q   <= '0;
      ct_wrdata_q <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      len_q       <= len_d;
      index_q     <= index_d;
      checksum_q  <= checksum_d;
      ct_wren_q   <= ct_wren_d;
      ct_addr_q   <= ct_addr_d;
      ct_wrdata_q <= ct_wrdata_d;
      done_q      <= done_d;
    end
  end

  assign ct_wren   = ct_wren_q;
  assign ct_addr   = ct_addr_q;
  assign ct_wrdata = ct_wrdata_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_ct_loader.sv
// Directed bench for ct_loader: hand-computed write sequences, done timing and checksums.
module tb_ct_loader;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] ct_addr;
  logic [7:0] ct_wrdata;
  logic       ct_wren;
  logic       done;
  logic [7:0] checksum;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;

  ct_loader #(.MEM_DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ct_addr   (ct_addr),
    .ct_wrdata (ct_wrdata),
    .ct_wren   (ct_wren),
    .done      (done),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally write strobes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (ct_wren === 1'b1) wr_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  // Advance one clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3;
    chk_cnt++; if (rdy !== 1'b1) $display("FAIL reset_rdy got %b exp 1", rdy); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
    chk_cnt++; if (ct_wren !== 1'b0) $display("FAIL reset_wren got %b exp 0", ct_wren); else pass_cnt++;
    chk_cnt++; if ({ct_addr, ct_wrdata} !== 16'h0000) $display("FAIL reset_addr_data got %h exp 0000", {ct_addr, ct_wrdata}); else pass_cnt++;
    chk_cnt++; if ({done, checksum} !== 9'h000) $display("FAIL reset_done_cks got %h exp 000", {done, checksum}); else pass_cnt++;
    step(); step();
    rst_n = 1'b1;
    step();
    chk_cnt++; if (rdy !== 1'b1 || in_ready !== 1'b0) $display("FAIL idle_after_reset got rdy=%b in_ready=%b exp 1/0", rdy, in_ready); else pass_cnt++;
  endtask

  // L=3, bytes A1 B2 C3 with in_valid held high.
  task automatic test_basic();
    logic [7:0] bytes [4];
    int w0;
    bytes[0] = 8'h03; bytes[1] = 8'hA1; bytes[2] = 8'hB2; bytes[3] = 8'hC3;
    w0 = wr_cnt;
    en = 1'b1;
    step();
    en = 1'b0;
    chk_cnt++; if (rdy !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_start got rdy=%b in_ready=%b exp 0/1", rdy, in_ready); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = bytes[i];
      step();
      chk_cnt++;
      if (ct_wren !== 1'b1 || ct_addr !== 8'(i) || ct_wrdata !== bytes[i])
        $display("FAIL basic_write%0d got wren=%b addr=%h data=%h exp 1/%h/%h", i, ct_wren, ct_addr, ct_wrdata, 8'(i), bytes[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    chk_cnt++; if (in_ready !== 1'b0 || done !== 1'b0 || rdy !== 1'b0) $display("FAIL basic_flush got in_ready=%b done=%b rdy=%b exp 0/0/0", in_ready, done, rdy); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b1 || rdy !== 1'b1 || ct_wren !== 1'b0) $display("FAIL basic_done got done=%b rdy=%b wren=%b exp 1/1/0", done, rdy, ct_wren); else pass_cnt++;
    chk_cnt++; if (checksum !== 8'hD0) $display("FAIL basic_checksum got %h exp d0", checksum); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", done); else pass_cnt++;
    chk_cnt++; if (checksum !== 8'hD0 || ct_addr !== 8'h03 || ct_wrdata !== 8'hC3) $display("FAIL basic_hold got cks=%h addr=%h data=%h exp d0/03/c3", checksum, ct_addr, ct_wrdata); else pass_cnt++;
    chk_cnt++; if (wr_cnt - w0 !== 4) $display("FAIL basic_write_count got %0d exp 4", wr_cnt - w0); else pass_cnt++;
  endtask

  // L=0: only the length byte is written.
  task automatic test_zero();
    int w0;
    w0 = wr_cnt;
    en = 1'b1;
    step();
    en = 1'b0;
    chk_cnt++; if (checksum !== 8'h00) $display("FAIL zero_cks_clear got %h exp 00", checksum); else pass_cnt++;
    in_valid = 1'b1; in_data = 8'h00;
    step();
    in_valid = 1'b0;
    chk_cnt++; if (ct_wren !== 1'b1 || ct_addr !== 8'h00 || ct_wrdata !== 8'h00 || in_ready !== 1'b0)
      $display("FAIL zero_write got wren=%b addr=%h data=%h in_ready=%b exp 1/00/00/0", ct_wren, ct_addr, ct_wrdata, in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b1 || rdy !== 1'b1 || checksum !== 8'h00) $display("FAIL zero_done got done=%b rdy=%b cks=%h exp 1/1/00", done, rdy, checksum); else pass_cnt++;
    step();
    chk_cnt++; if (wr_cnt - w0 !== 1) $display("FAIL zero_write_count got %0d exp 1", wr_cnt - w0); else pass_cnt++;
  endtask

  // L=255 with data 01..FF: every address 00..FF written once, no wrap.
  task automatic test_full();
    int w0;
    int bad;
    w0 = wr_cnt; bad = 0;
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1; in_data = (i == 0) ? 8'hFF : 8'(i);
      step();
      if (ct_wren !== 1'b1 || ct_addr !== 8'(i) || ct_wrdata !== ((i == 0) ? 8'hFF : 8'(i))) begin
        if (bad < 4) $display("full: write %0d wrong, wren=%b addr=%h data=%h", i, ct_wren, ct_addr, ct_wrdata);
        bad++;
      end
    end
    in_valid = 1'b0;
    chk_cnt++; if (bad !== 0) $display("FAIL full_writes got %0d bad exp 0", bad); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_flush got in_ready=%b exp 0", in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b1 || checksum !== 8'h00) $display("FAIL full_done got done=%b cks=%h exp 1/00", done, checksum); else pass_cnt++;
    chk_cnt++; if (wr_cnt - w0 !== 256) $display("FAIL full_write_count got %0d exp 256", wr_cnt - w0); else pass_cnt++;
    step();
  endtask

  // L=2, data valid pattern 1,0,0,1: stalls produce no write and keep the index.
  task automatic test_stall();
    int w0;
    w0 = wr_cnt;
    en = 1'b1;
    step();
    en = 1'b0;
    in_valid = 1'b1; in_data = 8'h02;
    step();
    in_valid = 1'b1; in_data = 8'h11;
    step();
    chk_cnt++; if (ct_wren !== 1'b1 || ct_addr !== 8'h01 || ct_wrdata !== 8'h11) $display("FAIL stall_first got wren=%b addr=%h data=%h exp 1/01/11", ct_wren, ct_addr, ct_wrdata); else pass_cnt++;
    for (int s = 0; s < 2; s++) begin
      in_valid = 1'b0; in_data = 8'h99;
      step();
      chk_cnt++;
      if (ct_wren !== 1'b0 || in_ready !== 1'b1 || ct_addr !== 8'h01 || ct_wrdata !== 8'h11)
        $display("FAIL stall_cycle%0d got wren=%b in_ready=%b addr=%h data=%h exp 0/1/01/11", s, ct_wren, in_ready, ct_addr, ct_wrdata);
      else pass_cnt++;
    end
    in_valid = 1'b1; in_data = 8'h22;
    step();
    in_valid = 1'b0;
    chk_cnt++; if (ct_wren !== 1'b1 || ct_addr !== 8'h02 || ct_wrdata !== 8'h22 || in_ready !== 1'b0)
      $display("FAIL stall_last got wren=%b addr=%h data=%h in_ready=%b exp 1/02/22/0", ct_wren, ct_addr, ct_wrdata, in_ready); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b1 || checksum !== 8'h33) $display("FAIL stall_done got done=%b cks=%h exp 1/33", done, checksum); else pass_cnt++;
    chk_cnt++; if (wr_cnt - w0 !== 3) $display("FAIL stall_write_count got %0d exp 3", wr_cnt - w0); else pass_cnt++;
    step();
  endtask

  // en pulsed during DATA must not restart the job or clear the checksum.
  task automatic test_en_ignored();
    logic [7:0] bytes [4];
    int d0;
    bytes[0] = 8'h03; bytes[1] = 8'h10; bytes[2] = 8'h20; bytes[3] = 8'h40;
    d0 = done_cnt;
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = bytes[i];
      en = (i == 2);
      step();
      chk_cnt++;
      if (ct_wren !== 1'b1 || ct_addr !== 8'(i) || ct_wrdata !== bytes[i] || rdy !== 1'b0)
        $display("FAIL enign_write%0d got wren=%b addr=%h data=%h rdy=%b exp 1/%h/%h/0", i, ct_wren, ct_addr, ct_wrdata, rdy, 8'(i), bytes[i]);
      else pass_cnt++;
    end
    en = 1'b0; in_valid = 1'b0;
    step(); step(); step();
    chk_cnt++; if (done_cnt - d0 !== 1) $display("FAIL enign_done_count got %0d exp 1", done_cnt - d0); else pass_cnt++;
    chk_cnt++; if (checksum !== 8'h70 || rdy !== 1'b1) $display("FAIL enign_checksum got cks=%h rdy=%b exp 70/1", checksum, rdy); else pass_cnt++;
  endtask

  // Reset after 2 of 5 data bytes aborts at once; the next job starts again at address 0.
  task automatic test_reset_midjob();
    int w0;
    en = 1'b1;
    step();
    en = 1'b0;
    in_valid = 1'b1; in_data = 8'h05;
    step();
    in_data = 8'h01;
    step();
    in_data = 8'h02;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if (ct_wren !== 1'b0 || ct_addr !== 8'h00 || ct_wrdata !== 8'h00) $display("FAIL rst_mid_write got wren=%b addr=%h data=%h exp 0/00/00", ct_wren, ct_addr, ct_wrdata); else pass_cnt++;
    chk_cnt++; if (rdy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || checksum !== 8'h00)
      $display("FAIL rst_mid_ctrl got rdy=%b in_ready=%b done=%b cks=%h exp 1/0/0/00", rdy, in_ready, done, checksum); else pass_cnt++;
    w0 = wr_cnt;
    in_data = 8'h03;
    step(); step();
    chk_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL rst_mid_no_write got %0d exp 0", wr_cnt - w0); else pass_cnt++;
    in_valid = 1'b0;
    en = 1'b1;
    rst_n = 1'b1;
    step();
    en = 1'b0;
    chk_cnt++; if (rdy !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_first_en got rdy=%b in_ready=%b exp 0/1", rdy, in_ready); else pass_cnt++;
    in_valid = 1'b1; in_data = 8'h01;
    step();
    chk_cnt++; if (ct_wren !== 1'b1 || ct_addr !== 8'h00 || ct_wrdata !== 8'h01) $display("FAIL rst_new_len got wren=%b addr=%h data=%h exp 1/00/01", ct_wren, ct_addr, ct_wrdata); else pass_cnt++;
    in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    chk_cnt++; if (ct_wren !== 1'b1 || ct_addr !== 8'h01 || ct_wrdata !== 8'h5A) $display("FAIL rst_new_data got wren=%b addr=%h data=%h exp 1/01/5a", ct_wren, ct_addr, ct_wrdata); else pass_cnt++;
    step();
    chk_cnt++; if (done !== 1'b1 || checksum !== 8'h5A) $display("FAIL rst_new_done got done=%b cks=%h exp 1/5a", done, checksum); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_full();
    test_stall();
    test_en_ignored();
    test_reset_midjob();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Safety net in case stimulus ever stops advancing.
  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
